// File: rtl/ahb_sram_bridge_pkg.sv
// Shared AHB-Lite encodings and the byte-lane mask helper for the SRAM bridge.
package ahb_sram_bridge_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Sizes wider than a word still enable the full 32-bit lane set.
  function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] addr_lo);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr_lo;
      HSIZE_HALF: m = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ahb_sram_bridge.sv
// Zero-wait-state AHB-Lite slave in front of a 1-cycle synchronous SRAM.
// Writes go through a one-entry buffer that drains whenever the SRAM port is free of reads.
module ahb_sram_bridge
  import ahb_sram_bridge_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          hsel,
  input  logic          hready,
  input  logic [1:0]    htrans,
  input  logic          hwrite,
  input  logic [2:0]    hsize,
  input  logic [31:0]   haddr,
  input  logic [31:0]   hwdata,
  output logic          hreadyout,
  output logic          hresp,
  output logic [31:0]   hrdata,
  output logic [AW-1:0] sram_addr,
  output logic [31:0]   sram_din,
  output logic [3:0]    sram_ben,
  output logic          sram_wren,
  input  logic [31:0]   sram_dout
);

  logic          xfer_valid;
  logic          rd_ap;
  logic          wr_ap;
  logic          drain;
  logic [AW-1:0] ap_addr;

  logic          wr_pend;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_mask;

  logic          buf_valid;
  logic [AW-1:0] buf_addr;
  logic [3:0]    buf_mask;
  logic [31:0]   buf_data;

  logic          rd_dp;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] addr_hold;

  logic          unused_ok;

  assign xfer_valid = hsel & hready & htrans[1];
  assign rd_ap      = xfer_valid & ~hwrite;
  assign wr_ap      = xfer_valid & hwrite;
  assign ap_addr    = haddr[AW+1:2];
  assign drain      = buf_valid & ~rd_ap;
  assign unused_ok  = ^{haddr[31:AW+2], htrans[0]};

  assign hreadyout  = 1'b1;
  assign hresp      = 1'b0;
  assign sram_din   = buf_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
      wr_mask <= '0;
    end else begin
      wr_pend <= wr_ap;
      if (wr_ap) begin
        wr_addr <= ap_addr;
        wr_mask <= byte_mask(hsize, haddr[1:0]);
      end
    end
  end

  // A reload in the data phase wins over a same-cycle drain of the older entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid <= 1'b0;
      buf_addr  <= '0;
      buf_mask  <= '0;
      buf_data  <= '0;
    end else if (wr_pend) begin
      buf_valid <= 1'b1;
      buf_addr  <= wr_addr;
      buf_mask  <= wr_mask;
      buf_data  <= hwdata;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_dp     <= 1'b0;
      rd_addr   <= '0;
      addr_hold <= '0;
    end else begin
      rd_dp     <= rd_ap;
      addr_hold <= sram_addr;
      if (rd_ap) rd_addr <= ap_addr;
    end
  end

  always_comb begin
    sram_addr = addr_hold;
    sram_ben  = 4'b0000;
    sram_wren = 1'b0;
    if (rd_ap) begin
      sram_addr = ap_addr;
      sram_ben  = 4'b1111;
    end else if (buf_valid) begin
      sram_addr = buf_addr;
      sram_ben  = buf_mask;
      sram_wren = 1'b1;
    end
  end

  // Bytes still sitting in the buffer are newer than what the SRAM returned.
  always_comb begin
    hrdata = sram_dout;
    if (rd_dp && buf_valid && (buf_addr == rd_addr)) begin
      for (int b = 0; b < 4; b++) begin
        if (buf_mask[b]) hrdata[8*b +: 8] = buf_data[8*b +: 8];
      end
    end
  end

  // A W,W,R address sequence would overwrite an undrained entry; masters must not issue it.
  a_no_buf_overrun: assert property (@(posedge clk) disable iff (!rst_n)
                                     !(wr_pend && buf_valid && !drain));

endmodule

// File: tb/tb_ahb_sram_bridge.sv
// Randomized bench for ahb_sram_bridge against a flat byte-addressed memory model.
module tb_ahb_sram_bridge;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hsel, hready, hwrite;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] haddr, hwdata;
  logic        hreadyout, hresp;
  logic [31:0] hrdata;
  logic [9:0]  sram_addr;
  logic [31:0] sram_din;
  logic [3:0]  sram_ben;
  logic        sram_wren;
  logic [31:0] sram_dout;

  int n_checks = 0;
  int n_errors = 0;

  ahb_sram_bridge dut (
    .clk(clk), .rst_n(rst_n),
    .hsel(hsel), .hready(hready), .htrans(htrans), .hwrite(hwrite),
    .hsize(hsize), .haddr(haddr), .hwdata(hwdata),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata),
    .sram_addr(sram_addr), .sram_din(sram_din), .sram_ben(sram_ben),
    .sram_wren(sram_wren), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'(i) * 32'h9E37_79B1 ^ 32'hA5C3_0000;
  endfunction

  // SRAM model plus a log of every write strobe it sees
  logic [31:0] sram_mem [1024];
  bit          mem_loaded = 1'b0;
  int          wr_cnt = 0;
  logic [9:0]  wr_log [$];
  logic [3:0]  last_ben;

  always @(posedge clk) begin
    logic [31:0] w;
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] <= init_word(i);
      mem_loaded <= 1'b1;
    end else begin
      sram_dout <= sram_mem[sram_addr];
      if (sram_wren) begin
        w = sram_mem[sram_addr];
        for (int b = 0; b < 4; b++) if (sram_ben[b]) w[8*b +: 8] = sram_din[8*b +: 8];
        sram_mem[sram_addr] <= w;
        wr_cnt <= wr_cnt + 1;
        wr_log.push_back(sram_addr);
        last_ben <= sram_ben;
      end
    end
  end

  logic [31:0] ref_mem [1024];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] lanes_of(input logic [2:0] sz, input logic [1:0] off);
    if (sz == 3'd0) return 4'(1 << off);
    if (sz == 3'd1) return 4'(4'h3 << (off & 2'd2));
    return 4'hF;
  endfunction

  // Previous address phase, now in its data phase
  logic        dp_rd = 1'b0, dp_wr = 1'b0;
  logic [9:0]  dp_word;
  logic [3:0]  dp_mask;
  logic [31:0] dp_wdata;

  task automatic step(input logic sel, input logic rdy, input logic [1:0] trans, input logic wr,
                      input logic [31:0] addr, input logic [2:0] sz, input logic [31:0] wdata);
    logic v;
    v = sel & rdy & trans[1];
    hsel = sel; hready = rdy; htrans = trans; hwrite = wr; haddr = addr; hsize = sz;
    hwdata = dp_wr ? dp_wdata : $urandom;
    @(negedge clk);
    check_val("hreadyout", 32'(hreadyout), 32'd1);
    check_val("hresp", 32'(hresp), 32'd0);
    if (dp_rd) check_val("hrdata", hrdata, ref_mem[dp_word]);
    @(posedge clk); #1;
    if (dp_wr)
      for (int b = 0; b < 4; b++) if (dp_mask[b]) ref_mem[dp_word][8*b +: 8] = dp_wdata[8*b +: 8];
    dp_rd = v & ~wr;
    dp_wr = v & wr;
    dp_word = addr[11:2];
    dp_mask = lanes_of(sz, addr[1:0]);
    dp_wdata = wdata;
  endtask

  task automatic wr_op(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    step(1'b1, 1'b1, 2'b10, 1'b1, a, sz, d);
  endtask
  task automatic rd_op(input logic [31:0] a);
    step(1'b1, 1'b1, 2'b10, 1'b0, a, 3'd2, 32'h0);
  endtask
  task automatic idle();
    step(1'b0, 1'b1, 2'b00, 1'b0, 32'h0, 3'd2, 32'h0);
  endtask

  initial begin
    int c0;
    logic [31:0] saved;
    bit w1, w2;
    int mism;

    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    rst_n = 1'b0; hsel = 1'b0; hready = 1'b1; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; haddr = '0; hwdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_hreadyout", 32'(hreadyout), 32'd1);
    check_val("rst_hresp", 32'(hresp), 32'd0);
    check_val("rst_wren", 32'(sram_wren), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Word write then read back; exactly one full-word strobe
    c0 = wr_cnt;
    wr_op(32'h000, 3'd2, 32'h1234_5678);
    idle(); idle();
    rd_op(32'h000); idle();
    check_val("s1_wr_count", 32'(wr_cnt - c0), 32'd1);
    check_val("s1_ben", 32'(last_ben), 32'hF);

    // Byte write with an immediate read of the same word: merge, then drain
    c0 = wr_cnt;
    wr_op(32'h005, 3'd0, {4{8'hAB}});
    rd_op(32'h004);
    check_val("s2_no_drain_on_read", 32'(wr_cnt - c0), 32'd0);
    idle();
    check_val("s2_drain_count", 32'(wr_cnt - c0), 32'd1);
    check_val("s2_drain_addr", 32'(wr_log[$]), 32'd1);
    check_val("s2_drain_ben", 32'(last_ben), 32'h2);

    // Byte write held across four back-to-back reads
    c0 = wr_cnt;
    wr_op(32'h010, 3'd0, {4{8'h11}});
    repeat (4) rd_op(32'h010);
    check_val("s3_held", 32'(wr_cnt - c0), 32'd0);
    idle();
    check_val("s3_drain_count", 32'(wr_cnt - c0), 32'd1);
    check_val("s3_drain_addr", 32'(wr_log[$]), 32'd4);

    // Back-to-back word writes drain one per cycle
    c0 = wr_cnt;
    wr_op(32'h020, 3'd2, 32'hA0A0_0001);
    wr_op(32'h024, 3'd2, 32'hB0B0_0002);
    wr_op(32'h028, 3'd2, 32'hC0C0_0003);
    idle(); idle(); idle();
    check_val("s4_count", 32'(wr_cnt - c0), 32'd3);
    check_val("s4_addr0", 32'(wr_log[wr_log.size()-3]), 32'd8);
    check_val("s4_addr1", 32'(wr_log[wr_log.size()-2]), 32'd9);
    check_val("s4_addr2", 32'(wr_log[wr_log.size()-1]), 32'd10);
    rd_op(32'h020); rd_op(32'h024); rd_op(32'h028); idle();

    // Halfword write lost to a reset before its drain
    c0 = wr_cnt;
    saved = ref_mem[12];
    wr_op(32'h032, 3'd1, {2{16'hCAFE}});
    idle();
    rst_n = 1'b0;
    ref_mem[12] = saved;
    dp_rd = 1'b0; dp_wr = 1'b0;
    #1;
    check_val("s5_wren_in_reset", 32'(sram_wren), 32'd0);
    repeat (2) begin
      @(negedge clk);
      check_val("s5_wren_in_reset", 32'(sram_wren), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rd_op(32'h030); idle();
    check_val("s5_no_write", 32'(wr_cnt - c0), 32'd0);

    // Non-transfers carrying hwrite must not touch the SRAM
    c0 = wr_cnt;
    step(1'b0, 1'b1, 2'b10, 1'b1, 32'h040, 3'd2, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 2'b01, 1'b1, 32'h040, 3'd2, 32'hDEAD_BEEF);
    step(1'b1, 1'b0, 2'b10, 1'b1, 32'h040, 3'd2, 32'hDEAD_BEEF);
    step(1'b1, 1'b1, 2'b00, 1'b1, 32'h040, 3'd2, 32'hDEAD_BEEF);
    idle(); idle();
    check_val("s6_no_access", 32'(wr_cnt - c0), 32'd0);
    rd_op(32'h040); idle();

    // Random traffic over a small window so merges and overlaps are frequent
    w1 = 1'b0; w2 = 1'b0;
    for (int n = 0; n < 800; n++) begin
      int kind, word;
      logic [1:0] off;
      logic [2:0] sz;
      logic [31:0] a;
      bit is_wr;
      kind = $urandom_range(0, 9);
      word = $urandom_range(0, 15);
      sz   = 3'($urandom_range(0, 2));
      off  = 2'($urandom_range(0, 3));
      if (sz == 3'd1) off = off & 2'b10;
      if (sz == 3'd2) off = 2'b00;
      a = ($urandom & 32'hFFFF_F000) | 32'(word << 2) | 32'(off);
      is_wr = 1'b0;
      if (kind <= 3) begin
        if (w1 && w2) idle();
        else step(1'b1, 1'b1, ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b10, 1'b0, a, sz, 32'h0);
      end else if (kind <= 7) begin
        step(1'b1, 1'b1, 2'b10, 1'b1, a, sz, $urandom);
        is_wr = 1'b1;
      end else begin
        case ($urandom_range(0, 3))
          0: step(1'b0, 1'b1, 2'b10, 1'($urandom), a, sz, $urandom);
          1: step(1'b1, 1'b1, 2'b01, 1'($urandom), a, sz, $urandom);
          2: step(1'b1, 1'b1, 2'b00, 1'($urandom), a, sz, $urandom);
          default: if (!dp_rd && !dp_wr) step(1'b1, 1'b0, 2'b10, 1'($urandom), a, sz, $urandom);
                   else idle();
        endcase
      end
      w2 = w1;
      w1 = is_wr;
    end
    idle(); idle(); idle();

    mism = 0;
    for (int i = 0; i < 1024; i++) if (sram_mem[i] !== ref_mem[i]) mism++;
    check_val("mem_image", 32'(mism), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
